// File: rtl/carry_select_seq_ctrl.sv
// carry_select_seq_ctrl
// Computes a 4*NIBBLES-bit sum on one shared external 4-bit adder, one nibble
// per clock, LSB nibble first. The carry between nibbles is held in carry_q.
// Operands come in on a valid/ready source and the result goes out on a
// valid/ready sink.
//
// Optional feature, selected with `define CSA_SUB_EN:
//   Adds an op_sub_i port that is latched with the operands. When op_sub_i=1,
//   the block computes a - b: B is inverted and the initial carry is 1.
//   In that mode cout_o=1 means no borrow occurred (a >= b).
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o=1
// RUN   | feeding nibble idx_q to the adder, capturing one sum nibble per edge
// DONE  | result held stable until the sink takes it
module carry_select_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES,
    localparam int IDX_W   = $clog2(NIBBLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef CSA_SUB_EN
    input  logic             op_sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_cin_o,
    input  logic [3:0]       add_f_i,
    input  logic             add_cout_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [3:0]         b_nib;
`ifdef CSA_SUB_EN
    logic               sub_q, sub_d;
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CSA_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CSA_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Next-state and adder drive. The adder inputs are held at zero outside RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef CSA_SUB_EN
        sub_d     = sub_q;
`endif
        b_nib     = '0;
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
`ifdef CSA_SUB_EN
                    sub_d   = op_sub_i;
                    carry_d = op_sub_i ? 1'b1 : cin_i;
`else
                    carry_d = cin_i;
`endif
                end
            end
            RUN: begin
                b_nib     = b_q[4*idx_q +: 4];
                add_a_o   = a_q[4*idx_q +: 4];
`ifdef CSA_SUB_EN
                add_b_o   = sub_q ? ~b_nib : b_nib;
`else
                add_b_o   = b_nib;
`endif
                add_cin_o = carry_q;
                sum_d[4*idx_q +: 4] = add_f_i;
                carry_d   = add_cout_i;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout_i;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_carry_select_seq_ctrl.sv
// Bench for carry_select_seq_ctrl: a NIBBLES=4 instance gets directed corner
// cases, a reset-in-RUN case and random operations. A NIBBLES=2 instance
// receives a back-to-back random stream, checked through an expected-result
// queue. Each instance has a behavioural 4-bit adder attached.
module tb_carry_select_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- NIBBLES=4 instance ----------------
    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0, sum4;
    logic        cin4 = 1'b0, cout4;
    logic [3:0]  add_a4, add_b4, add_f4;
    logic        add_cin4, add_cout4;
`ifdef CSA_SUB_EN
    logic        op_sub4 = 1'b0;
`endif

    assign {add_cout4, add_f4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

    carry_select_seq_ctrl #(.NIBBLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .a_i(a4), .b_i(b4), .cin_i(cin4),
`ifdef CSA_SUB_EN
        .op_sub_i(op_sub4),
`endif
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .sum_o(sum4), .cout_o(cout4),
        .add_a_o(add_a4), .add_b_o(add_b4), .add_cin_o(add_cin4),
        .add_f_i(add_f4), .add_cout_i(add_cout4)
    );

    // ---------------- NIBBLES=2 instance ----------------
    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1;
    logic [7:0]  a2 = '0, b2 = '0, sum2;
    logic        cin2 = 1'b0, cout2;
    logic [3:0]  add_a2, add_b2, add_f2;
    logic        add_cin2, add_cout2;
`ifdef CSA_SUB_EN
    logic        op_sub2 = 1'b0;
`endif

    assign {add_cout2, add_f2} = 5'(add_a2) + 5'(add_b2) + 5'(add_cin2);

    carry_select_seq_ctrl #(.NIBBLES(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .a_i(a2), .b_i(b2), .cin_i(cin2),
`ifdef CSA_SUB_EN
        .op_sub_i(op_sub2),
`endif
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .sum_o(sum2), .cout_o(cout2),
        .add_a_o(add_a2), .add_b_o(add_b2), .add_cin_o(add_cin2),
        .add_f_i(add_f2), .add_cout_i(add_cout2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // The expected result follows from the arithmetic definition:
    // add -> a+b+cin, 17 bits; sub -> (a-b) mod 2^16 with cout = no borrow.
    function automatic logic [16:0] ref4(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic sub);
        if (sub) return {(a >= b), 16'(a - b)};
        return 17'(a) + 17'(b) + 17'(c);
    endfunction

    // Performs one operation on the 4-nibble instance. During RUN and DONE,
    // in_valid is held high with junk data when hold>0 (the junk must be
    // ignored). The sink stalls for 'hold' cycles in DONE.
    task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic sub, input int hold);
        int k;
        logic [16:0] exp;
        exp = ref4(a, b, c, sub);
        k = 0;
        while (!in_ready4 && k < 50) begin @(posedge clk); #1; k++; end
        check_val("op4_in_ready", 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1; out_ready4 = (hold == 0);
`ifdef CSA_SUB_EN
        op_sub4 = sub;
`endif
        @(posedge clk); #1;
        in_valid4 = (hold > 0);
        a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        // k counts edges including the accept edge; out_valid must appear at edge NIBBLES+1.
        k = 1;
        while (!out_valid4 && k < 50) begin @(posedge clk); #1; k++; end
        check_val("op4_latency", 32'(k), 32'd5);
        check_val("op4_sum", 32'({cout4, sum4}), 32'(exp));
        check_val("op4_add_idle", 32'({add_a4, add_b4, add_cin4}), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 32'({out_valid4, in_ready4}), 32'b10);
            check_val("hold_sum", 32'({cout4, sum4}), 32'(exp));
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        @(posedge clk); #1;
        check_val("op4_consumed", 32'({out_valid4, in_ready4}), 32'b01);
    endtask

    localparam int N2_OPS = 400;
    logic [8:0] exp2_q[$];
    int         acc_q[$];

    task automatic pick_op2(input int i);
        case (i)
            0: begin a2 = 8'hFF; b2 = 8'h01; cin2 = 1'b0; end
            1: begin a2 = 8'hFF; b2 = 8'h00; cin2 = 1'b1; end
            2: begin a2 = 8'hFF; b2 = 8'hFF; cin2 = 1'b1; end
            3: begin a2 = 8'h00; b2 = 8'h00; cin2 = 1'b0; end
            default: begin a2 = 8'($urandom); b2 = 8'($urandom); cin2 = 1'($urandom); end
        endcase
    endtask

    initial begin
        int n_ops, n_done, cyc, last_acc, lat;
        logic [8:0] e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hs", 32'({in_ready4, out_valid4}), 32'b10);
        check_val("rst_res", 32'({cout4, sum4}), 32'd0);
        check_val("rst_add", 32'({add_a4, add_b4, add_cin4}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        run_op4(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op4(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op4(16'h1234, 16'h4321, 1'b1, 1'b0, 3);
`ifdef CSA_SUB_EN
        run_op4(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op4(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        run_op4(16'h8000, 16'h8000, 1'b0, 1'b1, 1);
`endif

        // Reset asserted while nibble 2 is being processed
        a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
`ifdef CSA_SUB_EN
        op_sub4 = 1'b0;
`endif
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_val("run_nib2", 32'({add_a4, add_b4}), 32'h23);
        rst = 1'b1;
        #1;
        check_val("rst_run_hs", 32'({in_ready4, out_valid4}), 32'b10);
        check_val("rst_run_res", 32'({cout4, sum4}), 32'd0);
        check_val("rst_run_add", 32'({add_a4, add_b4, add_cin4}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_run_out", 32'({in_ready4, out_valid4}), 32'b10);
        run_op4(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

        // Random operations on the 4-nibble instance
        for (int i = 0; i < 40; i++) begin
            logic s;
            s = 1'b0;
`ifdef CSA_SUB_EN
            s = 1'($urandom);
`endif
            run_op4(16'($urandom), 16'($urandom), 1'($urandom), s,
                    int'($urandom_range(0, 2)));
        end

        // Back-to-back stream on the 2-nibble instance, in_valid held high
        n_ops = 0; n_done = 0; cyc = 0; last_acc = -1;
        pick_op2(0);
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        while (n_done < N2_OPS && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (out_valid2) begin
                if (exp2_q.size() == 0) begin
                    check_val("n2_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp2_q.pop_front();
                    lat = acc_q.pop_front();
                    check_val("n2_sum", 32'({cout2, sum2}), 32'(e));
                    check_val("n2_latency", 32'(cyc - lat), 32'd3);
                end
                n_done++;
            end
            if (in_ready2 && in_valid2) begin
                exp2_q.push_back(9'(a2) + 9'(b2) + 9'(cin2));
                acc_q.push_back(cyc);
                if (last_acc >= 0) check_val("n2_throughput", 32'(cyc - last_acc), 32'd4);
                last_acc = cyc;
                n_ops++;
                @(posedge clk); #1;
                if (n_ops < N2_OPS) pick_op2(n_ops);
                else in_valid2 = 1'b0;
            end
        end
        check_val("n2_count", 32'(n_done), 32'(N2_OPS));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
